// File: rtl/patch_stream_scheduler.sv
// rtl/patch_stream_scheduler.sv - patch-major image reader streaming pixels with patch/frame framing
// Optional macro PATCH_POS_TAG_EN adds out_patch_idx / out_pos_idx tags to every pixel.
module patch_stream_scheduler #(
  parameter int CHANNEL_SIZE = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int PIXEL_WIDTH  = CHANNEL_SIZE*NUM_CHANNELS,
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 64,
  parameter int PATCH_SIZE   = 4,
  parameter int ROW_W        = $clog2(IMG_HEIGHT),
  parameter int COL_W        = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ROW_W-1:0]       mem_rd_row,
  output logic [COL_W-1:0]       mem_rd_col,
  input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_sop,
  output logic                   out_eop,
`ifdef PATCH_POS_TAG_EN
  output logic [$clog2((IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE))-1:0] out_patch_idx,
  output logic [$clog2(PATCH_SIZE*PATCH_SIZE)-1:0]                           out_pos_idx,
`endif
  output logic                   out_eof
);

  localparam int NPC  = IMG_WIDTH / PATCH_SIZE;
  localparam int NPR  = IMG_HEIGHT / PATCH_SIZE;
  localparam int C_W  = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
  localparam int PC_W = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int PR_W = (NPR > 1) ? $clog2(NPR) : 1;
`ifdef PATCH_POS_TAG_EN
  localparam int PIDX_W = $clog2(NPC*NPR);
  localparam int POS_W  = $clog2(PATCH_SIZE*PATCH_SIZE);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [C_W-1:0]  c, r;
  logic [PC_W-1:0] pc;
  logic [PR_W-1:0] pr;
  logic last_c, last_r, last_pc, last_pr, last_addr;

  logic       issue, inflight, push, pop;
  logic [1:0] count;
  logic [2:0] occ;
  logic       wr_ptr, rd_ptr;

  logic [PIXEL_WIDTH-1:0] fifo_data [2];
  logic [1:0] fifo_sop, fifo_eop, fifo_eof;
  logic       pend_sop, pend_eop, pend_eof;
`ifdef PATCH_POS_TAG_EN
  logic [PIDX_W-1:0] fifo_patch [2];
  logic [POS_W-1:0]  fifo_pos [2];
  logic [PIDX_W-1:0] pend_patch;
  logic [POS_W-1:0]  pend_pos;
`endif

  assign last_c    = (c  == C_W'(PATCH_SIZE-1));
  assign last_r    = (r  == C_W'(PATCH_SIZE-1));
  assign last_pc   = (pc == PC_W'(NPC-1));
  assign last_pr   = (pr == PR_W'(NPR-1));
  assign last_addr = last_c & last_r & last_pc & last_pr;

  assign mem_rd_row = ROW_W'(int'(pr) * PATCH_SIZE + int'(r));
  assign mem_rd_col = COL_W'(int'(pc) * PATCH_SIZE + int'(c));
  assign mem_rd_en  = issue;

  assign push      = inflight;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // Occupancy as it will stand after this cycle's pop; keeps FIFO + in-flight read at most 2.
  assign occ       = 3'(count) + 3'(inflight) - 3'(pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy  = 1'b1;
        issue = (occ < 3'd2);
        if (issue && last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      c  <= '0;
      r  <= '0;
      pc <= '0;
      pr <= '0;
    end else if (issue) begin
      if (!last_c) c <= c + 1'b1;
      else begin
        c <= '0;
        if (!last_r) r <= r + 1'b1;
        else begin
          r <= '0;
          if (!last_pc) pc <= pc + 1'b1;
          else begin
            pc <= '0;
            if (!last_pr) pr <= pr + 1'b1;
            else          pr <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= 1'b0;
      pend_sop     <= 1'b0;
      pend_eop     <= 1'b0;
      pend_eof     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_sop     <= '0;
      fifo_eop     <= '0;
      fifo_eof     <= '0;
`ifdef PATCH_POS_TAG_EN
      pend_patch    <= '0;
      pend_pos      <= '0;
      fifo_patch[0] <= '0;
      fifo_patch[1] <= '0;
      fifo_pos[0]   <= '0;
      fifo_pos[1]   <= '0;
`endif
    end else begin
      inflight <= issue;
      // Framing travels with the read so it lines up with the returning data.
      if (issue) begin
        pend_sop <= (c == '0) && (r == '0);
        pend_eop <= last_c & last_r;
        pend_eof <= last_addr;
`ifdef PATCH_POS_TAG_EN
        pend_patch <= PIDX_W'(int'(pr) * NPC + int'(pc));
        pend_pos   <= POS_W'(int'(r) * PATCH_SIZE + int'(c));
`endif
      end
      if (push) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_sop[wr_ptr]  <= pend_sop;
        fifo_eop[wr_ptr]  <= pend_eop;
        fifo_eof[wr_ptr]  <= pend_eof;
`ifdef PATCH_POS_TAG_EN
        fifo_patch[wr_ptr] <= pend_patch;
        fifo_pos[wr_ptr]   <= pend_pos;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign out_data = fifo_data[rd_ptr];
  assign out_sop  = fifo_sop[rd_ptr];
  assign out_eop  = fifo_eop[rd_ptr];
  assign out_eof  = fifo_eof[rd_ptr];
`ifdef PATCH_POS_TAG_EN
  assign out_patch_idx = fifo_patch[rd_ptr];
  assign out_pos_idx   = fifo_pos[rd_ptr];
`endif

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// tb/tb_patch_stream_scheduler.sv - scoreboard bench for patch_stream_scheduler (16x8 image, 4x4 patches)
// Define PATCH_POS_TAG_EN to also check the patch/position tags.
module tb_patch_stream_scheduler;
  localparam int CS = 8, NCH = 3, PW = CS*NCH;
  localparam int IW = 16, IH = 8, PS = 4;
  localparam int RW = $clog2(IH), CW = $clog2(IW);
  localparam int NPC = IW/PS, NPR = IH/PS, NPIX = IW*IH;

  logic clk = 1'b0;
  logic reset, start, busy, done, mem_rd_en, out_valid, out_ready;
  logic out_sop, out_eop, out_eof;
  logic [RW-1:0] mem_rd_row;
  logic [CW-1:0] mem_rd_col;
  logic [PW-1:0] mem_rd_data, out_data;
`ifdef PATCH_POS_TAG_EN
  logic [$clog2(NPC*NPR)-1:0] out_patch_idx;
  logic [$clog2(PS*PS)-1:0]   out_pos_idx;
`endif

  patch_stream_scheduler #(
    .CHANNEL_SIZE(CS), .NUM_CHANNELS(NCH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .PATCH_SIZE(PS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_row(mem_rd_row), .mem_rd_col(mem_rd_col),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
`ifdef PATCH_POS_TAG_EN
    .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx),
`endif
    .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Image buffer: synchronous read, pixel value = row*IW + col
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= PW'(int'(mem_rd_row) * IW + int'(mem_rd_col));
  end

  typedef struct {
    logic [PW-1:0] data;
    logic sop, eop, eof;
    int patch, pos;
  } pix_t;
  pix_t exp_q[$];
  pix_t e;

  int tests = 0, fails = 0;
  int cyc = 0;
  int hs_frame = 0, first_cyc = 0, last_cyc = 0, eof_cyc = -10, frames_done = 0;
  int issued = 0, accepted = 0, max_out = 0;
  logic stalled = 1'b0;
  logic [PW+2:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference frame: patch-major, raster inside each patch
  task automatic push_frame();
    pix_t p;
    for (int pr = 0; pr < NPR; pr++)
      for (int pc = 0; pc < NPC; pc++)
        for (int r = 0; r < PS; r++)
          for (int c = 0; c < PS; c++) begin
            p.data  = PW'((pr*PS + r) * IW + (pc*PS + c));
            p.sop   = (r == 0 && c == 0);
            p.eop   = (r == PS-1 && c == PS-1);
            p.eof   = p.eop && pr == NPR-1 && pc == NPC-1;
            p.patch = pr*NPC + pc;
            p.pos   = r*PS + c;
            exp_q.push_back(p);
          end
  endtask

  // Monitor: samples on the falling edge, i.e. the handshake that completes at the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      issued = 0; accepted = 0; hs_frame = 0; stalled = 1'b0; eof_cyc = -10;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        if (out_valid) check("stall_hold", 64'({out_data, out_sop, out_eop, out_eof}), 64'(held));
      end
      if (mem_rd_en) issued++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) note_fail("unexpected_pixel");
        else begin
          e = exp_q.pop_front();
          check("pixel", 64'({out_data, out_sop, out_eop, out_eof}), 64'({e.data, e.sop, e.eop, e.eof}));
`ifdef PATCH_POS_TAG_EN
          check("patch_idx", 64'(out_patch_idx), 64'(e.patch));
          check("pos_idx", 64'(out_pos_idx), 64'(e.pos));
`endif
        end
        accepted++;
        hs_frame++;
        if (hs_frame == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (out_eof) eof_cyc = cyc;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (done) begin
        check("done_timing", 64'(cyc), 64'(eof_cyc + 1));
        check("frame_pixels", 64'(hs_frame), 64'(NPIX));
        frames_done++;
        hs_frame = 0;
        eof_cyc = -10;
      end
      stalled = out_valid && !out_ready;
      held = {out_data, out_sop, out_eop, out_eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input bit rnd);
    int n = 0;
    while (frames_done == base && n < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (frames_done == base) note_fail("frame_timeout");
    out_ready = 1'b1;
  endtask

  task automatic wait_pixels(input int target, input bit rnd);
    int n = 0;
    while (hs_frame < target && n < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (hs_frame < target) note_fail("pixel_wait_timeout");
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_outputs", 64'({busy, done, mem_rd_en, out_valid, out_sop, out_eop, out_eof}), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 64'({busy, mem_rd_en}), 64'd0);

    // Frame A: latency and full-rate throughput
    base = frames_done;
    push_frame();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_rd_en_c1", 64'(mem_rd_en), 64'd1);
    check("lat_addr_c1", 64'({mem_rd_row, mem_rd_col}), 64'd0);
    check("lat_busy_c1", 64'(busy), 64'd1);
    check("lat_valid_c1", 64'(out_valid), 64'd0);
    tick();
    check("lat_valid_c2", 64'(out_valid), 64'd0);
    tick();
    check("lat_valid_c3", 64'(out_valid), 64'd1);
    wait_done(base, 1'b0);
    check("frames_a", 64'(frames_done), 64'(base + 1));
    check("throughput", 64'(last_cyc - first_cyc), 64'(NPIX - 1));

    // Frame B: 10-cycle stall, extra start pulses in RUN and DRAIN
    base = frames_done;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pixels(10, 1'b0);
    out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("stall_outstanding", 64'(issued - accepted), 64'd2);
    check("stall_no_read", 64'(mem_rd_en), 64'd0);
    out_ready = 1'b1;
    wait_pixels(NPIX - 2, 1'b0);
    check("drain_busy", 64'({busy, mem_rd_en}), 64'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(base, 1'b0);
    repeat (5) tick();
    check("frames_b", 64'(frames_done), 64'(base + 1));
    check("after_b_idle", 64'(busy), 64'd0);

    // Frame C: random backpressure
    base = frames_done;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(base, 1'b1);
    check("frames_c", 64'(frames_done), 64'(base + 1));

    // Frame D: reset at pixel 20, then a fresh frame E
    base = frames_done;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pixels(20, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outputs", 64'({out_valid, busy, mem_rd_en, done}), 64'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("midrst_no_done", 64'(frames_done), 64'(base));
    check("midrst_idle", 64'({busy, out_valid}), 64'd0);
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_addr", 64'({mem_rd_en, mem_rd_row, mem_rd_col}), 64'(1 << (RW + CW)));
    wait_done(base, 1'b1);
    check("frames_e", 64'(frames_done), 64'(base + 1));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("max_outstanding_le2", 64'(max_out <= 2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/patch_stream_scheduler.md
Name: patch_stream_scheduler

Overview:
- Sequences patch extraction for the ViT front end. Walks the image buffer in patch-major order (patch by patch, raster within each patch) and reads one pixel per cycle through a 1-cycle-latency read port.
- Streams the pixels to the patch-embedding stage over a valid/ready interface, with patch and frame framing flags.
- Replaces bulk-copy patchification with a sequenced, backpressure-aware stream.

Parameters:
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
- IMG_WIDTH, 64, image columns
- IMG_HEIGHT, 64, image rows
- PATCH_SIZE, 4, patch edge in pixels; must divide IMG_WIDTH and IMG_HEIGHT
- ROW_W, $clog2(IMG_HEIGHT), row address width
- COL_W, $clog2(IMG_WIDTH), column address width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the frame's final pixel handshake
- mem_rd_en  out  1  read request to image buffer
- mem_rd_row  out  ROW_W  image row address
- mem_rd_col  out  COL_W  image column address
- mem_rd_data  in  PIXEL_WIDTH  read data, valid the cycle after mem_rd_en
- out_valid  out  1  pixel available
- out_ready  in  1  downstream accept
- out_data  out  PIXEL_WIDTH  pixel
- out_sop  out  1  first pixel of a patch (position 0)
- out_eop  out  1  last pixel of a patch (position PATCH_SIZE^2-1)
- out_eof  out  1  last pixel of the frame

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: all outputs 0, state IDLE, counters 0, FIFO empty, in-flight flag 0.
- Reset mid-frame: same values next cycle; any read in flight is discarded; no done pulse.
- State IDLE:
  - start=1 -> RUN and clear counters.
  - start while busy is ignored.
- State RUN, read issue:
  - Issue a read when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle.
  - Address of the issued read: row = pr*PATCH_SIZE + r, col = pc*PATCH_SIZE + c.
  - Counter nesting, innermost first: c (pixel column in patch), r (pixel row in patch), pc (patch column), pr (patch row).
  - Each counter wraps at PATCH_SIZE, IMG_WIDTH/PATCH_SIZE or IMG_HEIGHT/PATCH_SIZE respectively.
  - After the final address (last pr, pc, r, c) is issued -> DRAIN.
- State DRAIN: no reads. When the FIFO is empty, nothing is in flight and the last pixel has handshaked -> DONE.
- State DONE: done=1 for exactly one cycle -> IDLE.
- Read return: mem_rd_data is captured into a 2-entry FIFO in the cycle after mem_rd_en.
  - Flags sop/eop/eof are computed at issue time and travel with the data.
- Output:
  - out_valid = FIFO non-empty.
  - out_data and the flags are the FIFO head.
  - Held stable while out_valid & !out_ready.
- Latency: start in cycle 0 -> mem_rd_en with address (0,0) in cycle 1 -> out_valid in cycle 3.
- Throughput: with out_ready held high, one pixel per cycle and no bubbles after the first.
- Backpressure: the FIFO never overflows. With out_ready low, exactly 2 reads are issued beyond the accepted pixels, then issue stalls.
- Simultaneous push and pop in one cycle: count unchanged.
- Frame length: (IMG_WIDTH*IMG_HEIGHT) pixels and (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE) patches; out_eof coincides with the final out_eop.

Optional Feature:
- Macro: PATCH_POS_TAG_EN.
- When defined:
  - Extra outputs out_patch_idx, width $clog2(total patches), value pr*(IMG_WIDTH/PATCH_SIZE)+pc.
  - Extra output out_pos_idx, width $clog2(PATCH_SIZE^2), value r*PATCH_SIZE+c.
  - Both carried through the FIFO alongside the data and reset to 0.
- When undefined: these ports and FIFO bits do not exist; all other behaviour is identical.

Test Plan:
- Ordering (IMG 8x8, PATCH 4), memory returns row*8+col, out_ready=1, pulse start:
  - Exactly 64 pixels, in order 0,1,2,3,8,9,10,11,16,…,27,4,5,…
  - out_sop on pixels 0/16/32/48, out_eop on 15/31/47/63, out_eof only on pixel 63.
  - done pulses once, 1 cycle after the final handshake.
- Latency/throughput (defaults):
  - start in cycle 0 -> first mem_rd_en in cycle 1, out_valid in cycle 3.
  - All 4096 pixels arrive on consecutive cycles.
- Backpressure: out_ready low for 10 cycles mid-frame.
  - At most 2 reads outstanding beyond accepted pixels.
  - out_data stable while stalled; no pixel lost or duplicated.
  - Random out_ready (50%) over a full frame must match the reference order.
- start while busy (extra start pulses during RUN and DRAIN): ignored, single done, pixel count unchanged.
- Reset mid-frame (reset at pixel 20):
  - Next cycle out_valid=0, busy=0, mem_rd_en=0, no done.
  - A new start then produces a full frame from pixel (0,0).
- With PATCH_POS_TAG_EN (8x8/4): the pixel at image (5,6) reports patch_idx 3, pos_idx 6.
